// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared MDIO arbiter states, clause-22 opcodes and helpers
// Purpose: FSM state encoding and opcode constants shared by the arbiter RTL.
// Ports: none (package).
package mdio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_RETURN    = 2'd3
    } mdio_state_e;

    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [1:0] OP_READ     = 2'b10;
    localparam logic [1:0] OP_READ_INC = 2'b11;

    // Opcode 00 is not a legal clause-22 opcode; it is forwarded as-is but
    // sequenced like a write so the arbiter never waits for read data.
    function automatic logic op_is_read(input logic [1:0] op);
        logic r;
        case (op)
            OP_WRITE:             r = 1'b0;
            OP_READ, OP_READ_INC: r = 1'b1;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdio_rr_arb2.sv
// rtl/mdio_rr_arb2.sv - two-way round-robin grant with last-served pointer
// Purpose: combinational one-hot grant between two requesters; on contention
//          the requester not served last wins.
// Ports: clk_i/rst_i clock and async active-high reset, req_i request vector,
//        en_i arbitration window (pointer moves only when a grant is taken),
//        gnt_o one-hot grant.
module mdio_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // 1 = port 1 was served last; reset value makes port 0 win first.
    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (en_i && (|req_i)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/mdio_arbiter.sv
// rtl/mdio_arbiter.sv - arbitrates two MDIO requesters onto one mdio_master
// Purpose: accepts one command at a time from s0/s1, forwards it to the
//          master, waits for read data (with timeout) and returns it to the
//          requester that issued the read.
// Ports: clk125/reset; s0_*/s1_* requester command and read-result streams;
//        m_* master command and read-data handshakes; grant one-hot owner;
//        timeout one-cycle pulse on an aborted read.
module mdio_arbiter
    import mdio_pkg::*;
#(
    parameter int READ_TIMEOUT = 4096
) (
    input  logic        clk125,
    input  logic        reset,
    input  logic [4:0]  s0_cmd_phy_addr,
    input  logic [4:0]  s0_cmd_reg_addr,
    input  logic [15:0] s0_cmd_data,
    input  logic [1:0]  s0_cmd_opcode,
    input  logic        s0_cmd_valid,
    output logic        s0_cmd_ready,
    output logic [15:0] s0_data_out,
    output logic        s0_data_out_valid,
    input  logic        s0_data_out_ready,
    input  logic [4:0]  s1_cmd_phy_addr,
    input  logic [4:0]  s1_cmd_reg_addr,
    input  logic [15:0] s1_cmd_data,
    input  logic [1:0]  s1_cmd_opcode,
    input  logic        s1_cmd_valid,
    output logic        s1_cmd_ready,
    output logic [15:0] s1_data_out,
    output logic        s1_data_out_valid,
    input  logic        s1_data_out_ready,
    output logic [4:0]  m_cmd_phy_addr,
    output logic [4:0]  m_cmd_reg_addr,
    output logic [15:0] m_cmd_data,
    output logic [1:0]  m_cmd_opcode,
    output logic        m_cmd_valid,
    input  logic        m_cmd_ready,
    input  logic [15:0] m_data_out,
    input  logic        m_data_out_valid,
    output logic        m_data_out_ready,
    output logic [1:0]  grant,
    output logic        timeout
);

    localparam logic [15:0] TIMEOUT_CYC = 16'(READ_TIMEOUT);

    mdio_state_e state_q;
    logic [1:0]  grant_q;
    logic [4:0]  phy_q;
    logic [4:0]  reg_q;
    logic [15:0] wdata_q;
    logic [1:0]  op_q;
    logic        m_cmd_valid_q;
    logic [15:0] rdata_q;
    logic        s0_dv_q;
    logic        s1_dv_q;
    logic        timeout_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [1:0]  gnt;
    logic        in_idle;
    logic        rsp_accept;

    assign in_idle = (state_q == ST_IDLE);

    mdio_rr_arb2 u_arb (
        .clk_i (clk125),
        .rst_i (reset),
        .req_i ({s1_cmd_valid, s0_cmd_valid}),
        .en_i  (in_idle),
        .gnt_o (gnt)
    );

    // Ready is combinational in IDLE; held low while reset is asserted.
    assign s0_cmd_ready = in_idle & gnt[0] & ~reset;
    assign s1_cmd_ready = in_idle & gnt[1] & ~reset;

    assign m_cmd_phy_addr   = phy_q;
    assign m_cmd_reg_addr   = reg_q;
    assign m_cmd_data       = wdata_q;
    assign m_cmd_opcode     = op_q;
    assign m_cmd_valid      = m_cmd_valid_q;
    // Stray read data arriving while idle is sunk and dropped.
    assign m_data_out_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT_DATA);

    // Read data only ever appears on the port that owns the transaction.
    assign s0_data_out       = s0_dv_q ? rdata_q : 16'h0000;
    assign s1_data_out       = s1_dv_q ? rdata_q : 16'h0000;
    assign s0_data_out_valid = s0_dv_q;
    assign s1_data_out_valid = s1_dv_q;
    assign grant             = grant_q;
    assign timeout           = timeout_q;

    assign rsp_accept = (s0_dv_q & s0_data_out_ready) | (s1_dv_q & s1_data_out_ready);
    // cnt_q counts cycles since the read handshake (1 in the first wait cycle).
    assign cnt_d      = cnt_q + 16'd1;

    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'b00;
            phy_q         <= 5'd0;
            reg_q         <= 5'd0;
            wdata_q       <= 16'h0000;
            op_q          <= 2'b00;
            m_cmd_valid_q <= 1'b0;
            rdata_q       <= 16'h0000;
            s0_dv_q       <= 1'b0;
            s1_dv_q       <= 1'b0;
            timeout_q     <= 1'b0;
            cnt_q         <= 16'd0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        phy_q         <= gnt[1] ? s1_cmd_phy_addr : s0_cmd_phy_addr;
                        reg_q         <= gnt[1] ? s1_cmd_reg_addr : s0_cmd_reg_addr;
                        wdata_q       <= gnt[1] ? s1_cmd_data     : s0_cmd_data;
                        op_q          <= gnt[1] ? s1_cmd_opcode   : s0_cmd_opcode;
                        grant_q       <= gnt;
                        m_cmd_valid_q <= 1'b1;
                        state_q       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_cmd_ready) begin
                        m_cmd_valid_q <= 1'b0;
                        if (op_is_read(op_q)) begin
                            cnt_q   <= 16'd1;
                            state_q <= ST_WAIT_DATA;
                        end else begin
                            grant_q <= 2'b00;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (m_data_out_valid) begin
                        rdata_q <= m_data_out;
                        s0_dv_q <= grant_q[0];
                        s1_dv_q <= grant_q[1];
                        cnt_q   <= 16'd0;
                        state_q <= ST_RETURN;
                    end else if (cnt_d == TIMEOUT_CYC) begin
                        rdata_q   <= 16'hFFFF;
                        timeout_q <= 1'b1;
                        s0_dv_q   <= grant_q[0];
                        s1_dv_q   <= grant_q[1];
                        cnt_q     <= 16'd0;
                        state_q   <= ST_RETURN;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RETURN: begin
                    if (rsp_accept) begin
                        s0_dv_q <= 1'b0;
                        s1_dv_q <= 1'b0;
                        grant_q <= 2'b00;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_arbiter.sv
// tb/tb_mdio_arbiter.sv - directed self-checking bench for mdio_arbiter
module tb_mdio_arbiter;
    import mdio_pkg::*;

    logic        clk125 = 1'b0;
    logic        reset;
    logic [4:0]  s0_cmd_phy_addr, s0_cmd_reg_addr, s1_cmd_phy_addr, s1_cmd_reg_addr;
    logic [15:0] s0_cmd_data, s1_cmd_data;
    logic [1:0]  s0_cmd_opcode, s1_cmd_opcode;
    logic        s0_cmd_valid, s1_cmd_valid, s0_cmd_ready, s1_cmd_ready;
    logic [15:0] s0_data_out, s1_data_out;
    logic        s0_data_out_valid, s1_data_out_valid, s0_data_out_ready, s1_data_out_ready;
    logic [4:0]  m_cmd_phy_addr, m_cmd_reg_addr;
    logic [15:0] m_cmd_data, m_data_out;
    logic [1:0]  m_cmd_opcode, grant;
    logic        m_cmd_valid, m_cmd_ready, m_data_out_valid, m_data_out_ready, timeout;

    int total = 0;
    int bad   = 0;

    always #4 clk125 = ~clk125;

    mdio_arbiter #(.READ_TIMEOUT(16)) dut (
        .clk125(clk125), .reset(reset),
        .s0_cmd_phy_addr(s0_cmd_phy_addr), .s0_cmd_reg_addr(s0_cmd_reg_addr),
        .s0_cmd_data(s0_cmd_data), .s0_cmd_opcode(s0_cmd_opcode),
        .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(s0_cmd_ready),
        .s0_data_out(s0_data_out), .s0_data_out_valid(s0_data_out_valid),
        .s0_data_out_ready(s0_data_out_ready),
        .s1_cmd_phy_addr(s1_cmd_phy_addr), .s1_cmd_reg_addr(s1_cmd_reg_addr),
        .s1_cmd_data(s1_cmd_data), .s1_cmd_opcode(s1_cmd_opcode),
        .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(s1_cmd_ready),
        .s1_data_out(s1_data_out), .s1_data_out_valid(s1_data_out_valid),
        .s1_data_out_ready(s1_data_out_ready),
        .m_cmd_phy_addr(m_cmd_phy_addr), .m_cmd_reg_addr(m_cmd_reg_addr),
        .m_cmd_data(m_cmd_data), .m_cmd_opcode(m_cmd_opcode),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_data_out(m_data_out), .m_data_out_valid(m_data_out_valid),
        .m_data_out_ready(m_data_out_ready),
        .grant(grant), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd0(input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d, input logic [1:0] op);
        s0_cmd_phy_addr = phy; s0_cmd_reg_addr = rg; s0_cmd_data = d; s0_cmd_opcode = op; s0_cmd_valid = 1'b1;
    endtask

    task automatic cmd1(input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d, input logic [1:0] op);
        s1_cmd_phy_addr = phy; s1_cmd_reg_addr = rg; s1_cmd_data = d; s1_cmd_opcode = op; s1_cmd_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        s0_cmd_phy_addr = '0; s0_cmd_reg_addr = '0; s0_cmd_data = '0; s0_cmd_opcode = '0; s0_cmd_valid = 1'b0;
        s1_cmd_phy_addr = '0; s1_cmd_reg_addr = '0; s1_cmd_data = '0; s1_cmd_opcode = '0; s1_cmd_valid = 1'b0;
        s0_data_out_ready = 1'b0; s1_data_out_ready = 1'b0;
        m_cmd_ready = 1'b0; m_data_out = '0; m_data_out_valid = 1'b0;

        // reset state
        repeat (2) @(negedge clk125);
        s0_cmd_valid = 1'b1;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s0_rdy", s0_cmd_ready, 1'b0);
        chk("rst_mvalid", m_cmd_valid, 1'b0);
        chk("rst_mdrdy", m_data_out_ready, 1'b1);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_dv", {s0_data_out_valid, s1_data_out_valid}, 2'b00);
        chk("rst_mdata", m_cmd_data, 16'h0000);
        s0_cmd_valid = 1'b0;
        @(negedge clk125);
        reset = 1'b0;

        // both valid after reset: s0 first, then s1
        @(negedge clk125);
        cmd0(5'd4, 5'd4, 16'hAAAA, OP_WRITE);
        cmd1(5'd5, 5'd5, 16'hBBBB, OP_WRITE);
        #1;
        chk("rr0_s0_rdy", s0_cmd_ready, 1'b1);
        chk("rr0_s1_rdy", s1_cmd_ready, 1'b0);
        @(negedge clk125);
        s0_cmd_valid = 1'b0;
        #1;
        chk("rr0_grant", grant, 2'b01);
        chk("rr0_mdata", m_cmd_data, 16'hAAAA);
        chk("rr0_mvalid", m_cmd_valid, 1'b1);
        chk("rr0_s1_rdy_busy", s1_cmd_ready, 1'b0);
        m_cmd_ready = 1'b1;
        @(negedge clk125);
        m_cmd_ready = 1'b0;
        #1;
        chk("rr1_grant_idle", grant, 2'b00);
        chk("rr1_s1_rdy", s1_cmd_ready, 1'b1);
        @(negedge clk125);
        s1_cmd_valid = 1'b0;
        #1;
        chk("rr1_grant", grant, 2'b10);
        chk("rr1_mdata", m_cmd_data, 16'hBBBB);
        m_cmd_ready = 1'b1;
        @(negedge clk125);
        m_cmd_ready = 1'b0;
        #1;
        chk("rr1_done_grant", grant, 2'b00);
        chk("rr1_done_mvalid", m_cmd_valid, 1'b0);

        // s0 write phy 1 reg 0 data 0x1140, s1 idle
        cmd0(5'd1, 5'd0, 16'h1140, OP_WRITE);
        #1;
        chk("wr_s0_rdy", s0_cmd_ready, 1'b1);
        @(negedge clk125);
        s0_cmd_valid = 1'b0;
        #1;
        chk("wr_phy", m_cmd_phy_addr, 5'd1);
        chk("wr_reg", m_cmd_reg_addr, 5'd0);
        chk("wr_data", m_cmd_data, 16'h1140);
        chk("wr_op", m_cmd_opcode, 2'b01);
        chk("wr_grant", grant, 2'b01);
        @(negedge clk125);
        #1;
        chk("wr_mvalid_hold", m_cmd_valid, 1'b1);
        m_cmd_ready = 1'b1;
        @(negedge clk125);
        m_cmd_ready = 1'b0;
        #1;
        chk("wr_grant_done", grant, 2'b00);
        chk("wr_mvalid_done", m_cmd_valid, 1'b0);

        // contention again with s0 served last: s1 then s0
        cmd0(5'd6, 5'd6, 16'hCCCC, OP_WRITE);
        cmd1(5'd7, 5'd7, 16'hDDDD, OP_WRITE);
        #1;
        chk("rr2_s1_rdy", s1_cmd_ready, 1'b1);
        chk("rr2_s0_rdy", s0_cmd_ready, 1'b0);
        @(negedge clk125);
        s1_cmd_valid = 1'b0;
        #1;
        chk("rr2_grant", grant, 2'b10);
        chk("rr2_mdata", m_cmd_data, 16'hDDDD);
        m_cmd_ready = 1'b1;
        @(negedge clk125);
        m_cmd_ready = 1'b0;
        #1;
        chk("rr3_s0_rdy", s0_cmd_ready, 1'b1);
        @(negedge clk125);
        s0_cmd_valid = 1'b0;
        #1;
        chk("rr3_grant", grant, 2'b01);
        chk("rr3_mdata", m_cmd_data, 16'hCCCC);
        m_cmd_ready = 1'b1;
        @(negedge clk125);
        m_cmd_ready = 1'b0;
        #1;
        chk("rr3_done", grant, 2'b00);

        // s1 read reg 1, master returns 0x796D, s1 stalls 10 cycles
        cmd1(5'd2, 5'd1, 16'h0000, OP_READ);
        #1;
        chk("rd_s1_rdy", s1_cmd_ready, 1'b1);
        @(negedge clk125);
        s1_cmd_valid = 1'b0;
        #1;
        chk("rd_grant", grant, 2'b10);
        chk("rd_op", m_cmd_opcode, 2'b10);
        chk("rd_reg", m_cmd_reg_addr, 5'd1);
        chk("rd_mdrdy_issue", m_data_out_ready, 1'b0);
        m_cmd_ready = 1'b1;
        @(negedge clk125);
        m_cmd_ready = 1'b0;
        #1;
        chk("rd_mdrdy_wait", m_data_out_ready, 1'b1);
        chk("rd_mvalid_off", m_cmd_valid, 1'b0);
        m_data_out = 16'h796D;
        m_data_out_valid = 1'b1;
        @(negedge clk125);
        m_data_out_valid = 1'b0;
        m_data_out = 16'h0000;
        cmd0(5'd8, 5'd8, 16'hEEEE, OP_WRITE);
        #1;
        chk("rd_mdrdy_ret", m_data_out_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("hold_s1_dv", s1_data_out_valid, 1'b1);
            chk("hold_s1_data", s1_data_out, 16'h796D);
            chk("hold_s0_dv", s0_data_out_valid, 1'b0);
            chk("hold_s0_rdy", s0_cmd_ready, 1'b0);
            @(negedge clk125);
            #1;
        end
        s1_data_out_ready = 1'b1;
        @(negedge clk125);
        s1_data_out_ready = 1'b0;
        #1;
        chk("ret_s1_dv_off", s1_data_out_valid, 1'b0);
        chk("ret_grant", grant, 2'b00);
        chk("ret_s0_rdy", s0_cmd_ready, 1'b1);
        @(negedge clk125);
        s0_cmd_valid = 1'b0;
        #1;
        chk("ret_s0_grant", grant, 2'b01);
        m_cmd_ready = 1'b1;
        @(negedge clk125);
        m_cmd_ready = 1'b0;

        // s0 read with no master data: timeout 16 cycles after handshake
        cmd0(5'd3, 5'd2, 16'h0000, OP_READ_INC);
        #1;
        chk("to_s0_rdy", s0_cmd_ready, 1'b1);
        @(negedge clk125);
        s0_cmd_valid = 1'b0;
        m_cmd_ready = 1'b1;
        @(negedge clk125);
        m_cmd_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("to_early", {timeout, s0_data_out_valid}, 2'b00);
            @(negedge clk125);
        end
        #1;
        chk("to_pulse", timeout, 1'b1);
        chk("to_s0_dv", s0_data_out_valid, 1'b1);
        chk("to_s0_data", s0_data_out, 16'hFFFF);
        chk("to_s1_dv", s1_data_out_valid, 1'b0);
        @(negedge clk125);
        #1;
        chk("to_pulse_end", timeout, 1'b0);
        chk("to_s0_dv_hold", s0_data_out_valid, 1'b1);
        s0_data_out_ready = 1'b1;
        @(negedge clk125);
        s0_data_out_ready = 1'b0;
        #1;
        chk("to_done_dv", s0_data_out_valid, 1'b0);
        chk("to_done_grant", grant, 2'b00);

        // reset while waiting for read data
        cmd1(5'd9, 5'd3, 16'h0000, OP_READ);
        @(negedge clk125);
        s1_cmd_valid = 1'b0;
        m_cmd_ready = 1'b1;
        @(negedge clk125);
        m_cmd_ready = 1'b0;
        repeat (3) @(negedge clk125);
        reset = 1'b1;
        #1;
        chk("mrst_grant", grant, 2'b00);
        chk("mrst_mvalid", m_cmd_valid, 1'b0);
        chk("mrst_phy", m_cmd_phy_addr, 5'd0);
        chk("mrst_mdrdy", m_data_out_ready, 1'b1);
        chk("mrst_dv", {s0_data_out_valid, s1_data_out_valid, timeout}, 3'b000);
        @(negedge clk125);
        reset = 1'b0;
        m_data_out = 16'hDEAD;
        m_data_out_valid = 1'b1;
        @(negedge clk125);
        m_data_out_valid = 1'b0;
        m_data_out = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("mrst_quiet", {s0_data_out_valid, s1_data_out_valid, timeout, grant}, 5'b00000);
            @(negedge clk125);
        end
        cmd0(5'd1, 5'd2, 16'h0000, OP_READ);
        @(negedge clk125);
        s0_cmd_valid = 1'b0;
        m_cmd_ready = 1'b1;
        @(negedge clk125);
        m_cmd_ready = 1'b0;
        m_data_out = 16'h1234;
        m_data_out_valid = 1'b1;
        @(negedge clk125);
        m_data_out_valid = 1'b0;
        #1;
        chk("post_s0_dv", s0_data_out_valid, 1'b1);
        chk("post_s0_data", s0_data_out, 16'h1234);
        chk("post_s1_dv", s1_data_out_valid, 1'b0);
        s0_data_out_ready = 1'b1;
        @(negedge clk125);
        s0_data_out_ready = 1'b0;
        #1;
        chk("post_grant", grant, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
